// File: rtl/lsu_dmem_responder_if.sv
// ----------------------------------------------------------------------------
// lsu_dmem_responder_if
//
// LSU <-> data-memory request/response bundle.
//   rready_cpu  : read request from the CPU, held until rvalid_cpu is seen
//   rvalid_cpu  : one-cycle read-response pulse from memory
//   wvalid_cpu  : write request from the CPU, held until wready_cpu is seen
//   wready_cpu  : one-cycle write-acknowledge pulse from memory
//   strb_cpu    : byte write strobes, bit i covers data_cpu_o[8i+7:8i]
//   addr_cpu    : byte address, bits [1:0] ignored by the memory
//   data_cpu_o  : write data, CPU -> memory
//   data_cpu_i  : read data, memory -> CPU
//
// master = CPU/LSU side, slave = memory responder side.
// ----------------------------------------------------------------------------
interface lsu_dmem_responder_if;
    logic        rready_cpu;
    logic        rvalid_cpu;
    logic        wvalid_cpu;
    logic        wready_cpu;
    logic [3:0]  strb_cpu;
    logic [31:0] addr_cpu;
    logic [31:0] data_cpu_o;
    logic [31:0] data_cpu_i;

    modport master (
        output rready_cpu, wvalid_cpu, strb_cpu, addr_cpu, data_cpu_o,
        input  rvalid_cpu, wready_cpu, data_cpu_i
    );

    modport slave (
        input  rready_cpu, wvalid_cpu, strb_cpu, addr_cpu, data_cpu_o,
        output rvalid_cpu, wready_cpu, data_cpu_i
    );
endinterface

// File: rtl/lsu_dmem_responder.sv
// ----------------------------------------------------------------------------
// lsu_dmem_responder
//
// Memory-side responder for the LSU request/response interface. Serves
// word-aligned reads and byte-strobed writes from an internal SRAM of
// 2**ADDR_WIDTH_D words, inserting WAIT_STATES idle cycles before each
// response, and flags accesses outside [BASE_ADDR, BASE_ADDR + 4*DEPTH).
//
// Ports:
//   clk      : clock, everything on the rising edge
//   rst      : synchronous active-high reset
//   bus      : slave end of lsu_dmem_responder_if (requests in, pulses out)
//   bus_err  : sticky out-of-window flag
//   err_addr : byte address of the first out-of-window access
//
// Transaction flow: IDLE -> WAIT (WAIT_STATES cycles, skipped when 0) ->
// RESP -> GAP -> IDLE. SRAM write/read, bus_err and err_addr all happen on
// the edge entering RESP; the registered response pulse appears on the
// edge leaving RESP, so it is high while the FSM sits in GAP.
// ----------------------------------------------------------------------------
module lsu_dmem_responder #(
    parameter int          ADDR_WIDTH_D = 10,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          WAIT_STATES  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    lsu_dmem_responder_if.slave  bus,
    output logic                 bus_err,
    output logic [31:0]          err_addr
);

    localparam int         DEPTH     = 2 ** ADDR_WIDTH_D;
    localparam int         WIN_LSB   = ADDR_WIDTH_D + 2;
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP, GAP} state_t;

    state_t      state;
    logic [3:0]  wait_cnt;

    // Request captured on acceptance; the CPU may drop its request afterwards.
    logic        lat_wr;
    logic [31:0] lat_addr;
    logic [31:0] lat_data;
    logic [3:0]  lat_strb;

    logic [31:0] mem [DEPTH];

    logic                    accept;
    logic                    enter_resp;
    logic                    txn_wr;
    logic [31:0]             txn_addr;
    logic [31:0]             txn_data;
    logic [3:0]              txn_strb;
    logic                    in_win;
    logic [ADDR_WIDTH_D-1:0] word_idx;

    // With WAIT_STATES=0 the FSM goes IDLE->RESP in one edge, so the request
    // has not been latched yet when the SRAM access happens; in IDLE the live
    // bus values stand in for the latched ones.
    always_comb begin
        accept = (state == IDLE) && (bus.wvalid_cpu || bus.rready_cpu);
        if (state == IDLE) begin
            txn_wr   = bus.wvalid_cpu;
            txn_addr = bus.addr_cpu;
            txn_data = bus.data_cpu_o;
            txn_strb = bus.strb_cpu;
        end else begin
            txn_wr   = lat_wr;
            txn_addr = lat_addr;
            txn_data = lat_data;
            txn_strb = lat_strb;
        end
        enter_resp = (accept && (WAIT_STATES == 0)) ||
                     ((state == WAIT) && (wait_cnt == WAIT_LAST));
        // BASE_ADDR is window-size aligned, so the window test is an equality
        // on the upper bits and the word index is just the low address bits.
        in_win   = (txn_addr[31:WIN_LSB] == BASE_ADDR[31:WIN_LSB]);
        word_idx = txn_addr[WIN_LSB-1:2];
    end

    // Control FSM and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            bus.rvalid_cpu <= 1'b0;
            bus.wready_cpu <= 1'b0;
            bus.data_cpu_i <= '0;
            bus_err        <= 1'b0;
            err_addr       <= '0;
        end else begin
            bus.rvalid_cpu <= 1'b0;
            bus.wready_cpu <= 1'b0;

            if (enter_resp) begin
                if (!txn_wr) begin
                    bus.data_cpu_i <= in_win ? mem[word_idx] : '0;
                end
                if (!in_win) begin
                    bus_err <= 1'b1;
                    if (!bus_err) begin
                        err_addr <= txn_addr;
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        wait_cnt <= '0;
                        state    <= (WAIT_STATES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                RESP: begin
                    if (lat_wr) begin
                        bus.wready_cpu <= 1'b1;
                    end else begin
                        bus.rvalid_cpu <= 1'b1;
                    end
                    state <= GAP;
                end
                GAP: begin
                    // Swallows a request still held during the response pulse.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Request capture (data path, no reset). Write wins over a simultaneous read.
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_wr   <= bus.wvalid_cpu;
            lat_addr <= bus.addr_cpu;
            lat_data <= bus.data_cpu_o;
            lat_strb <= bus.strb_cpu;
        end
    end

    // SRAM write port. Gated by rst so a write interrupted by reset never lands.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && txn_wr && in_win) begin
            for (int b = 0; b < 4; b++) begin
                if (txn_strb[b]) begin
                    mem[word_idx][8*b +: 8] <= txn_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_lsu_dmem_responder
//
// Directed bench for lsu_dmem_responder. Main instance uses WAIT_STATES=1;
// two extra instances (WAIT_STATES=0 and 4) cover response latency.
// The bench models a registered CPU: a request stays high through the edge
// that ends the response pulse and is dropped right after it.
// ----------------------------------------------------------------------------
module tb_lsu_dmem_responder;

    logic        clk;
    logic        rst;
    logic        bus_err, bus_err0, bus_err4;
    logic [31:0] err_addr, err_addr0, err_addr4;

    int total = 0;
    int bad   = 0;

    lsu_dmem_responder_if bus  ();
    lsu_dmem_responder_if bus0 ();
    lsu_dmem_responder_if bus4 ();

    lsu_dmem_responder #(.ADDR_WIDTH_D(10), .BASE_ADDR(32'h0), .WAIT_STATES(1)) dut (
        .clk(clk), .rst(rst), .bus(bus), .bus_err(bus_err), .err_addr(err_addr)
    );

    lsu_dmem_responder #(.ADDR_WIDTH_D(10), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut_ws0 (
        .clk(clk), .rst(rst), .bus(bus0), .bus_err(bus_err0), .err_addr(err_addr0)
    );

    lsu_dmem_responder #(.ADDR_WIDTH_D(10), .BASE_ADDR(32'h0), .WAIT_STATES(4)) dut_ws4 (
        .clk(clk), .rst(rst), .bus(bus4), .bus_err(bus_err4), .err_addr(err_addr4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One transaction on the WAIT_STATES=1 instance over a fixed 12-edge window.
    // lat = edge count (accept edge = 1) at which the pulse is first seen.
    task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, output logic [31:0] rdata,
                       output int lat, output int hits, output int wrong);
        lat   = 0;
        hits  = 0;
        wrong = 0;
        rdata = '0;
        bus.addr_cpu   = addr;
        bus.data_cpu_o = data;
        bus.strb_cpu   = strb;
        if (wr) bus.wvalid_cpu = 1'b1;
        else    bus.rready_cpu = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); #1;
            if (lat != 0 && n == lat + 1) begin
                bus.wvalid_cpu = 1'b0;
                bus.rready_cpu = 1'b0;
            end
            if (wr ? bus.wready_cpu : bus.rvalid_cpu) begin
                hits++;
                if (lat == 0) begin
                    lat   = n;
                    rdata = bus.data_cpu_i;
                end
            end
            if (wr ? bus.rvalid_cpu : bus.wready_cpu) wrong++;
        end
        bus.wvalid_cpu = 1'b0;
        bus.rready_cpu = 1'b0;
    endtask

    task automatic do_write(input string tag, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] rd;
        int lat, hits, wrong;
        txn(1'b1, addr, data, strb, rd, lat, hits, wrong);
        chk({tag, "_ack"}, hits, 1);
        chk({tag, "_norv"}, wrong, 0);
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        int lat, hits, wrong;
        txn(1'b0, addr, 32'h0, 4'h0, rd, lat, hits, wrong);
        chk({tag, "_data"}, rd, exp);
        chk({tag, "_rv"}, hits, 1);
    endtask

    initial begin
        logic [31:0] rd;
        int lat, hits, wrong;
        int nw, nr, wcnt, rcnt;
        int nb, nc, cb, cc;

        rst = 1'b1;
        bus.rready_cpu  = 1'b0; bus.wvalid_cpu  = 1'b0; bus.strb_cpu  = 4'h0;
        bus.addr_cpu    = '0;   bus.data_cpu_o  = '0;
        bus0.rready_cpu = 1'b0; bus0.wvalid_cpu = 1'b0; bus0.strb_cpu = 4'h0;
        bus0.addr_cpu   = '0;   bus0.data_cpu_o = '0;
        bus4.rready_cpu = 1'b0; bus4.wvalid_cpu = 1'b0; bus4.strb_cpu = 4'h0;
        bus4.addr_cpu   = '0;   bus4.data_cpu_o = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rvalid", bus.rvalid_cpu, 0);
        chk("rst_wready", bus.wready_cpu, 0);
        chk("rst_rdata", bus.data_cpu_i, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_err_addr", err_addr, 0);
        chk("rst_rdata_ws0", bus0.data_cpu_i, 0);
        chk("rst_rdata_ws4", bus4.data_cpu_i, 0);
        rst = 1'b0;

        // Full-word write then read back, latency 3 edges from the request
        txn(1'b1, 32'h10, 32'hCAFE_F00D, 4'hF, rd, lat, hits, wrong);
        chk("wr10_lat", lat, 3);
        chk("wr10_ack", hits, 1);
        chk("wr10_norv", wrong, 0);
        txn(1'b0, 32'h10, 32'h0, 4'h0, rd, lat, hits, wrong);
        chk("rd10_data", rd, 32'hCAFE_F00D);
        chk("rd10_lat", lat, 3);
        chk("rd10_rv", hits, 1);
        chk("rd10_nowr", wrong, 0);
        chk("rd10_err", bus_err, 0);

        // Byte strobes; read data holds across a write
        do_write("wr20_full", 32'h20, 32'h1122_3344, 4'hF);
        chk("rdata_hold", bus.data_cpu_i, 32'hCAFE_F00D);
        do_write("wr20_strb", 32'h23, 32'hAABB_CCDD, 4'b0101);
        do_read("rd20_strb", 32'h20, 32'h11BB_33DD);
        do_write("wr20_nostrb", 32'h20, 32'hFFFF_FFFF, 4'b0000);
        do_read("rd20_nostrb", 32'h20, 32'h11BB_33DD);

        // Out-of-window accesses; 0x1000 must not alias onto word 0
        do_write("wr0", 32'h0, 32'h0102_0304, 4'hF);
        do_write("wr_oow", 32'h0000_1000, 32'h9999_9999, 4'hF);
        chk("oow_bus_err", bus_err, 1);
        chk("oow_err_addr", err_addr, 32'h0000_1000);
        do_read("rd_oow", 32'h0000_2000, 32'h0);
        chk("oow2_err_addr", err_addr, 32'h0000_1000);
        chk("oow2_bus_err", bus_err, 1);
        do_read("rd0_noalias", 32'h0, 32'h0102_0304);

        // Simultaneous write and read: write first, read still served later
        bus.addr_cpu   = 32'h30;
        bus.data_cpu_o = 32'hDEAD_BEEF;
        bus.strb_cpu   = 4'hF;
        bus.wvalid_cpu = 1'b1;
        bus.rready_cpu = 1'b1;
        nw = 0; nr = 0; wcnt = 0; rcnt = 0; rd = '0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (nw != 0 && n == nw + 1) bus.wvalid_cpu = 1'b0;
            if (nr != 0 && n == nr + 1) bus.rready_cpu = 1'b0;
            if (bus.wready_cpu) begin
                wcnt++;
                if (nw == 0) nw = n;
            end
            if (bus.rvalid_cpu) begin
                rcnt++;
                if (nr == 0) begin
                    nr = n;
                    rd = bus.data_cpu_i;
                end
            end
        end
        bus.wvalid_cpu = 1'b0;
        bus.rready_cpu = 1'b0;
        chk("both_wr_lat", nw, 3);
        chk("both_rd_lat", nr, 7);
        chk("both_wr_cnt", wcnt, 1);
        chk("both_rd_cnt", rcnt, 1);
        chk("both_rd_data", rd, 32'hDEAD_BEEF);

        // Latency with WAIT_STATES=0 and 4 (offset from accept edge = lat-1)
        bus0.addr_cpu = 32'h8; bus0.data_cpu_o = 32'h1; bus0.strb_cpu = 4'hF;
        bus4.addr_cpu = 32'h8; bus4.data_cpu_o = 32'h1; bus4.strb_cpu = 4'hF;
        bus0.wvalid_cpu = 1'b1;
        bus4.wvalid_cpu = 1'b1;
        nb = 0; nc = 0; cb = 0; cc = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (nb != 0 && n == nb + 1) bus0.wvalid_cpu = 1'b0;
            if (nc != 0 && n == nc + 1) bus4.wvalid_cpu = 1'b0;
            if (bus0.wready_cpu) begin
                cb++;
                if (nb == 0) nb = n;
            end
            if (bus4.wready_cpu) begin
                cc++;
                if (nc == 0) nc = n;
            end
        end
        bus0.wvalid_cpu = 1'b0;
        bus4.wvalid_cpu = 1'b0;
        chk("ws0_offset", nb - 1, 1);
        chk("ws4_offset", nc - 1, 5);
        chk("ws0_cnt", cb, 1);
        chk("ws4_cnt", cc, 1);
        chk("ws0_err", bus_err0, 0);
        chk("ws4_err", bus_err4, 0);

        // Reset during WAIT of a write: no ack, SRAM untouched, flags cleared
        do_write("wr40", 32'h40, 32'h5555_5555, 4'hF);
        bus.addr_cpu   = 32'h40;
        bus.data_cpu_o = 32'h1234_5678;
        bus.strb_cpu   = 4'hF;
        bus.wvalid_cpu = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        bus.wvalid_cpu = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        hits = 0;
        for (int n = 0; n < 8; n++) begin
            if (bus.wready_cpu) hits++;
            @(posedge clk); #1;
        end
        chk("rstmid_noack", hits, 0);
        chk("rstmid_bus_err", bus_err, 0);
        chk("rstmid_err_addr", err_addr, 0);
        do_read("rd40_after_rst", 32'h40, 32'h5555_5555);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
